stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 10, giving clk cycles per count step (legal range 2..1024).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, single-cycle command to begin or resume counting.
REQ-005 The block SHALL have port stop, input, 1 bit, single-cycle command to pause counting.
REQ-006 The block SHALL have port clear, input, 1 bit, single-cycle command to return to IDLE with count zeroed.
REQ-007 The block SHALL have port limit_bcd, input, 16 bits, terminal value as 4 BCD digits, [15:12] most significant.
REQ-008 The block SHALL have port count_bcd, output, 16 bits, current 4-digit BCD count.
REQ-009 The block SHALL have port running, output, 1 bit, high only in RUN.
REQ-010 The block SHALL have port done, output, 1 bit, high only in DONE.
REQ-011 The block SHALL have port wrap, output, 1 bit, one-cycle pulse when count rolls 9999 -> 0000.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN, PAUSE and DONE.
REQ-013 Command priority SHALL be clear > stop > start when asserted in the same cycle.
REQ-014 clear in any state SHALL give IDLE, count 0000 and prescaler 0 on the next edge.
REQ-015 start in IDLE SHALL latch limit_bcd into an internal limit register, zero the prescaler and enter RUN.
REQ-016 start in IDLE with limit_bcd = 0000 SHALL enter DONE directly, without passing through RUN.
REQ-017 In RUN the prescaler SHALL count 0..TICK_DIV-1 and wrap; the cycle holding TICK_DIV-1 is the step cycle.
REQ-018 On a step cycle, count_bcd SHALL increment by one decimal at the closing edge.
REQ-019 Increment SHALL ripple: a digit at 9 goes to 0 and carries into the next digit; digits never hold A-F.
REQ-020 If the incremented count equals the latched limit, the FSM SHALL enter DONE on that same edge, with done high coincident with the new count.
REQ-021 On increment from 9999, count SHALL become 0000 with wrap high for that one cycle, and RUN continues.
REQ-022 A latched limit containing a nibble above 9 SHALL never match; the counter free-runs and wraps.
REQ-023 stop in RUN SHALL enter PAUSE, holding count and prescaler; a stop coinciding with a step cycle suppresses that step.
REQ-024 start in PAUSE SHALL return to RUN with prescaler and latched limit unchanged; limit_bcd is not resampled.
REQ-025 In DONE, count SHALL hold and start/stop are ignored; only clear or reset exits DONE.
REQ-026 start in RUN, or stop in IDLE, PAUSE or DONE, SHALL have no effect.
REQ-027 All outputs SHALL be registered or decoded directly from registered state.

Reset
REQ-028 While reset is high: state IDLE, count_bcd 0000, prescaler 0, latched limit 0000, running 0, done 0, wrap 0.
REQ-029 Reset asserted mid-count SHALL abort immediately and asynchronously, with no partial increment.
REQ-030 After reset release the block SHALL ignore nothing: a start in the first clocked cycle SHALL be honoured.

Structure
REQ-031 The state encoding and the BCD digit maximum constant (4'd9) SHALL live in the shared package stopwatch_pkg.
REQ-032 One sub-module bcd_digit (enable in, 4-bit digit out, carry out, synchronous zero, async reset) SHALL be instantiated 4 times in a carry chain.
REQ-033 Prescaler width SHALL be derived from TICK_DIV with $clog2.

Verification (TICK_DIV=4)
REQ-034 Reset, limit 0012, start -> running next cycle; count 0001 after 4 cycles; done with count 0012 after 48 cycles in RUN.
REQ-035 Count 0009 -> 0010 and count 0999 -> 1000 -> check digit carry chain; no A-F nibble observed at any time.
REQ-036 Limit FFFF, run to 9999 -> next step gives count 0000 with a one-cycle wrap pulse; running stays 1.
REQ-037 stop at prescaler 2, wait 20 cycles, start -> count unchanged during PAUSE; next step 2 cycles after resume.
REQ-038 start+stop+clear in the same cycle while in RUN -> IDLE, count 0000; stop on a step cycle -> no increment.
REQ-039 Reset pulse mid-RUN at count 0347 -> count 0000 and IDLE immediately; start with limit 0000 -> done next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
// Holds the FSM encoding, the digit maximum and a BCD increment helper.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } sw_state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Value the digit chain will hold after one step; used for limit match.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[4*i +: 4] == BCD_MAX) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle between a stopwatch controller and its user.
// The master issues commands, the slave reports count and status.
interface stopwatch_ctrl_if;

   logic        start;
   logic        stop;
   logic        clear;
   logic [15:0] limit_bcd;
   logic [15:0] count_bcd;
   logic        running;
   logic        done;
   logic        wrap;

   modport master (
      output start, stop, clear, limit_bcd,
      input  count_bcd, running, done, wrap
   );

   modport slave (
      input  start, stop, clear, limit_bcd,
      output count_bcd, running, done, wrap
   );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decimal digit of the count; carries out when stepped at 9.
// zero clears synchronously and wins over the enable.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       zero,
   output logic [3:0] digit,
   output logic       co
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit <= 4'd0;
      end else if (zero) begin
         digit <= 4'd0;
      end else if (en) begin
         digit <= (digit >= BCD_MAX) ? 4'd0 : digit + 4'd1;
      end
   end

   assign co = en && (digit == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch with prescaler, pause and terminal limit.
// Commands resolve as clear over stop over start.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 10
) (
   input  logic       clk,
   input  logic       reset,
   stopwatch_ctrl_if.slave sw
);

   localparam int PW = $clog2(TICK_DIV);

   sw_state_e      state, state_n;
   logic [PW-1:0]  pre;
   logic [15:0]    limit;
   logic [15:0]    count;
   logic [15:0]    cnt_nxt;
   logic [3:0]     en;
   logic [3:0]     co;
   logic           last;
   logic           adv;
   logic           step;
   logic           load;
   logic           wrap_q;

   assign last    = (pre == PW'(TICK_DIV - 1));
   assign adv     = (state == RUN) && !sw.clear && !sw.stop;
   assign step    = adv && last;
   assign cnt_nxt = bcd_inc(count);

   always_comb begin
      state_n = state;
      load    = 1'b0;
      priority case (1'b1)
         sw.clear: state_n = IDLE;
         sw.stop: begin
            if (state == RUN) state_n = PAUSE;
         end
         sw.start && (state == IDLE): begin
            load    = 1'b1;
            state_n = (sw.limit_bcd == 16'h0) ? DONE : RUN;
         end
         sw.start && (state == PAUSE): state_n = RUN;
         default: begin
            // A limit with a nibble above 9 can never equal cnt_nxt.
            if (step && (cnt_nxt == limit)) state_n = DONE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         pre    <= '0;
         limit  <= 16'h0;
         wrap_q <= 1'b0;
      end else begin
         state  <= state_n;
         wrap_q <= co[3];
         if (sw.clear || load) begin
            pre <= '0;
         end else if (adv) begin
            pre <= last ? '0 : pre + PW'(1);
         end
         if (load) limit <= sw.limit_bcd;
      end
   end

   assign en = {co[2:0], step};

   for (genvar g = 0; g < 4; g++) begin : g_dig
      bcd_digit u_dig (
         .clk   (clk),
         .reset (reset),
         .en    (en[g]),
         .zero  (sw.clear),
         .digit (count[4*g +: 4]),
         .co    (co[g])
      );
   end

   assign sw.count_bcd = count;
   assign sw.running   = (state == RUN);
   assign sw.done      = (state == DONE);
   assign sw.wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random commands,
// all checked against a decimal-arithmetic model of the stopwatch.
module tb_stopwatch_ctrl;

   localparam int TD = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   int   m_mode, m_cnt, m_pre, m_lim;
   bit   m_wrap;

   stopwatch_ctrl_if sw ();

   stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .clk   (clk),
      .reset (reset),
      .sw    (sw)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      int x;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int bcd2int(input logic [15:0] v);
      int acc, mul;
      acc = 0;
      mul = 1;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] > 4'd9) return -1;
         acc += int'(v[4*i +: 4]) * mul;
         mul *= 10;
      end
      return acc;
   endfunction

   function automatic logic valid_bcd(input logic [15:0] v);
      return bcd2int(v) >= 0;
   endfunction

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_pre  = 0;
      m_lim  = 0;
      m_wrap = 0;
   endtask

   task automatic model_step(input logic st, sp, cl,
                             input logic [15:0] lim);
      m_wrap = 0;
      if (cl) begin
         m_mode = M_IDLE;
         m_cnt  = 0;
         m_pre  = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (st && !sp) begin
               m_lim  = bcd2int(lim);
               m_pre  = 0;
               m_mode = (m_lim == 0) ? M_DONE : M_RUN;
            end
            M_RUN: if (sp) begin
               m_mode = M_PAUSE;
            end else if (m_pre == TD - 1) begin
               m_pre = 0;
               m_cnt = (m_cnt + 1) % 10000;
               if (m_cnt == 0) m_wrap = 1;
               if (m_cnt == m_lim) m_mode = M_DONE;
            end else begin
               m_pre++;
            end
            M_PAUSE: if (st && !sp) m_mode = M_RUN;
            default: ;
         endcase
      end
   endtask

   task automatic check_all();
      check("count", sw.count_bcd, int2bcd(m_cnt));
      check("running", 16'(sw.running), 16'(m_mode == M_RUN));
      check("done", 16'(sw.done), 16'(m_mode == M_DONE));
      check("wrap", 16'(sw.wrap), 16'(m_wrap));
      check("bcd_digits", 16'(valid_bcd(sw.count_bcd)), 16'd1);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cyc(input logic st, sp, cl, input logic [15:0] lim);
      sw.start     = st;
      sw.stop      = sp;
      sw.clear     = cl;
      sw.limit_bcd = lim;
      @(posedge clk);
      model_step(st, sp, cl, lim);
      #1 check_all();
      @(negedge clk);
      sw.start = 1'b0;
      sw.stop  = 1'b0;
      sw.clear = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, sw.limit_bcd);
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic rst_pulse();
      #2 reset = 1'b1;
      #1 model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int saved;
      int k;
      bit seen;
      logic [15:0] lim;
      reset        = 1'b1;
      sw.start     = 1'b0;
      sw.stop      = 1'b0;
      sw.clear     = 1'b0;
      sw.limit_bcd = 16'h0;
      #3 model_reset();
      check_all();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // start right after reset release, limit 0012
      cyc(1, 0, 0, 16'h0012);
      check("run_after_start", 16'(sw.running), 16'd1);
      idle(4);
      check("first_step", sw.count_bcd, 16'h0001);
      idle(43);
      check("not_done_47", 16'(sw.done), 16'd0);
      idle(1);
      check("done_48", 16'(sw.done), 16'd1);
      check("done_count", sw.count_bcd, 16'h0012);
      idle(6);
      cyc(1, 1, 0, 16'h0005);

      // pause at prescaler 2, resume
      cyc(0, 0, 1, 16'h0);
      cyc(1, 0, 0, 16'h0050);
      idle(5);
      k = 0;
      while (m_pre != 2 && k < 8) begin idle(1); k++; end
      saved = m_cnt;
      cyc(0, 1, 0, 16'h0050);
      for (int i = 0; i < 20; i++) begin
         cyc(0, 1'($urandom_range(0, 1)), 0, 16'h0);
         check("pause_hold", sw.count_bcd, int2bcd(saved));
      end
      cyc(1, 0, 0, 16'h0001);
      idle(1);
      check("resume_wait", sw.count_bcd, int2bcd(saved));
      idle(1);
      check("resume_step", sw.count_bcd, int2bcd(saved + 1));

      // stop coinciding with a step cycle
      k = 0;
      while (m_pre != 3 && k < 8) begin idle(1); k++; end
      saved = m_cnt;
      cyc(0, 1, 0, 16'h0);
      check("stop_on_step", sw.count_bcd, int2bcd(saved));
      cyc(1, 0, 0, 16'h0);
      idle(3);

      // all three commands at once while running
      cyc(1, 1, 1, 16'h0020);
      check("triple_count", sw.count_bcd, 16'h0000);
      check("triple_run", 16'(sw.running), 16'd0);

      // random command mix
      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 3))
            0: lim = int2bcd($urandom_range(0, 40));
            1: lim = 16'($urandom);
            2: lim = int2bcd($urandom_range(0, 9999));
            default: lim = 16'h0;
         endcase
         cyc(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 63) == 0), lim);
      end

      // reset mid-run at 0347, then zero limit
      cyc(0, 0, 1, 16'h0);
      cyc(1, 0, 0, 16'hFFFF);
      k = 0;
      while (m_cnt != 347 && k < 2000) begin idle(1); k++; end
      check("reach_0347", sw.count_bcd, 16'h0347);
      idle(1);
      rst_pulse();
      check("rst_count", sw.count_bcd, 16'h0000);
      check("rst_run", 16'(sw.running), 16'd0);
      cyc(1, 0, 0, 16'h0000);
      check("zero_limit_done", 16'(sw.done), 16'd1);
      cyc(1, 0, 0, 16'h0003);
      idle(8);
      check("done_hold", sw.count_bcd, 16'h0000);

      // run to 9999 and wrap
      cyc(0, 0, 1, 16'h0);
      cyc(1, 0, 0, 16'hFFFF);
      seen = 0;
      for (int i = 0; i < 41000 && !seen; i++) begin
         idle(1);
         if (m_wrap) seen = 1;
      end
      check("wrap_seen", 16'(seen), 16'd1);
      check("wrap_pulse", 16'(sw.wrap), 16'd1);
      check("wrap_count", sw.count_bcd, 16'h0000);
      check("wrap_running", 16'(sw.running), 16'd1);
      idle(1);
      check("wrap_once", 16'(sw.wrap), 16'd0);
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
